// File: rtl/lcd_num_formatter.sv
// Snapshot NUM_CH binary values and write each one as a LINE_LEN-character
// LCD field (label, ':', sign, decimal digits, padding), one character per cycle.
module lcd_num_formatter #(
  parameter int WIDTH    = 32,
  parameter int DIGITS   = 10,
  parameter int LINE_LEN = 16,
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = $clog2(NUM_CH*LINE_LEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NUM_CH*WIDTH-1:0] numbers,
  input  logic [NUM_CH*8-1:0]     labels,
  input  logic                    signed_mode,
  input  logic                    blank_zeros,
  output logic [7:0]              dat,
  output logic [ADDR_W-1:0]       addr,
  output logic                    we,
  output logic                    busy,
  output logic                    done
);

  localparam int AW = (WIDTH+4 > 4*DIGITS+1) ? WIDTH+4 : 4*DIGITS+1;
  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LW = $clog2(LINE_LEN+1);

  typedef enum logic [2:0] {
    S_IDLE, S_LABEL, S_COLON, S_SIGN, S_DIGIT, S_PAD, S_FIN
  } state_t;

  function automatic logic [AW-1:0] pow10(input int n);
    logic [AW-1:0] p;
    p = AW'(1);
    for (int i = 0; i < n; i++) p = p * AW'(10);
    return p;
  endfunction

  localparam logic [AW-1:0] LIMIT = pow10(DIGITS);

  logic [AW-1:0] pw [DIGITS];
  for (genvar i = 0; i < DIGITS; i++) begin : g_pw
    assign pw[i] = pow10(i);
  end

  state_t                  state;
  logic [NUM_CH*WIDTH-1:0] num_q;
  logic [NUM_CH*8-1:0]     lab_q;
  logic                    sgn_q;
  logic                    blk_q;
  logic [CW-1:0]           ch;
  logic [LW-1:0]           col;
  logic [KW-1:0]           k;
  logic [3:0]              cnt;
  logic [AW-1:0]           rem;
  logic                    ovf;
  logic                    lead;
  logic [ADDR_W-1:0]       wa;

  logic [WIDTH-1:0] val;
  logic [WIDTH:0]   nv;
  logic             neg;
  logic [AW-1:0]    mag;
  logic [7:0]       lab;

  // Negate in WIDTH+1 bits so the most negative input keeps its magnitude.
  always_comb begin
    val = num_q[ch*WIDTH +: WIDTH];
    lab = lab_q[ch*8 +: 8];
    neg = sgn_q & val[WIDTH-1];
    nv  = ~{1'b1, val} + {{WIDTH{1'b0}}, 1'b1};
    mag = neg ? AW'(nv) : AW'(val);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      dat   <= '0;
      addr  <= '0;
      we    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      num_q <= '0;
      lab_q <= '0;
      sgn_q <= 1'b0;
      blk_q <= 1'b0;
      ch    <= '0;
      col   <= '0;
      k     <= '0;
      cnt   <= '0;
      rem   <= '0;
      ovf   <= 1'b0;
      lead  <= 1'b0;
      wa    <= '0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            num_q <= numbers;
            lab_q <= labels;
            sgn_q <= signed_mode;
            blk_q <= blank_zeros;
            ch    <= '0;
            busy  <= 1'b1;
            we    <= 1'b1;
            dat   <= labels[7:0];
            addr  <= '0;
            wa    <= ADDR_W'(1);
            state <= S_COLON;
          end
        end
        S_LABEL: begin
          we    <= 1'b1;
          dat   <= lab;
          addr  <= wa;
          wa    <= wa + ADDR_W'(1);
          state <= S_COLON;
        end
        S_COLON: begin
          we    <= 1'b1;
          dat   <= 8'h3A;
          addr  <= wa;
          wa    <= wa + ADDR_W'(1);
          state <= S_SIGN;
        end
        S_SIGN: begin
          we    <= 1'b1;
          dat   <= neg ? 8'h2D : 8'h20;
          addr  <= wa;
          wa    <= wa + ADDR_W'(1);
          rem   <= mag;
          ovf   <= (mag >= LIMIT);
          k     <= KW'(DIGITS-1);
          cnt   <= '0;
          lead  <= 1'b1;
          state <= S_DIGIT;
        end
        S_DIGIT: begin
          // Repeated subtraction: each digit d takes d idle cycles then a write.
          if (!ovf && rem >= pw[k]) begin
            rem <= rem - pw[k];
            cnt <= cnt + 4'd1;
          end else begin
            we   <= 1'b1;
            addr <= wa;
            wa   <= wa + ADDR_W'(1);
            if (ovf)
              dat <= 8'h23;
            else if (blk_q && lead && cnt == 4'd0 && k != '0)
              dat <= 8'h20;
            else
              dat <= {4'h3, cnt};
            lead <= lead & (cnt == 4'd0);
            cnt  <= '0;
            if (k == '0) begin
              col <= LW'(3+DIGITS);
              if (3+DIGITS < LINE_LEN)
                state <= S_PAD;
              else if (ch == CW'(NUM_CH-1))
                state <= S_FIN;
              else begin
                ch    <= ch + CW'(1);
                state <= S_LABEL;
              end
            end else begin
              k <= k - KW'(1);
            end
          end
        end
        S_PAD: begin
          we   <= 1'b1;
          dat  <= 8'h20;
          addr <= wa;
          wa   <= wa + ADDR_W'(1);
          col  <= col + LW'(1);
          if (col == LW'(LINE_LEN-1)) begin
            if (ch == CW'(NUM_CH-1))
              state <= S_FIN;
            else begin
              ch    <= ch + CW'(1);
              state <= S_LABEL;
            end
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/lcd_num_formatter.md
Name: lcd_num_formatter

Overview:
Parametrised successor to the two-field binary-to-LCD converter. It snapshots NUM_CH binary values and renders each as one LINE_LEN-character LCD field: label, ':', sign, DIGITS decimal digits, space padding. Characters are written one per cycle into the LCD character RAM (dat/addr/we), and the block sits between the lock-in result registers and the LCD driver. Adds signed mode, leading-zero blanking, overflow marking, per-channel labels and a start/busy/done handshake.

Parameters:
WIDTH, 32, bit width of each input value
DIGITS, 10, decimal digit count per field; constraint 3+DIGITS <= LINE_LEN
LINE_LEN, 16, characters per channel field
NUM_CH, 2, number of channels/fields
ADDR_W, clog2(NUM_CH*LINE_LEN), character RAM address width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  single-cycle request; sampled only when busy=0
numbers  in  NUM_CH*WIDTH  channel values, channel 0 in the LSBs
labels  in  NUM_CH*8  ASCII label character per channel
signed_mode  in  1  1 = values are two's complement
blank_zeros  in  1  1 = leading zeros shown as space
dat  out  8  character code
addr  out  ADDR_W  character address = ch*LINE_LEN + col
we  out  1  write strobe; dat/addr valid in the same cycle
busy  out  1  conversion in progress
done  out  1  one-cycle pulse after the final write

Behaviour:
- Reset: dat=0, addr=0, we=0, busy=0, done=0, FSM=IDLE, internal registers cleared. Reset mid-operation aborts immediately, with no further writes.
- IDLE: start=1 captures numbers, labels, signed_mode and blank_zeros, then sets busy=1 next cycle. Later input changes are ignored until done. start while busy is ignored, with no queueing.
- Per channel ch=0..NUM_CH-1, one write per cycle unless noted:
  - col0: the label byte.
  - col1: ':' (0x3A).
  - col2: sign. '-' (0x2D) if signed_mode and the value MSB is 1, else ' ' (0x20). Magnitude = two's-complement negation in WIDTH+1 bits, so the most negative value is exact. The overflow flag is set this cycle if magnitude >= 10^DIGITS; arithmetic is at least WIDTH+4 bits wide.
  - col3..col3+DIGITS-1, DIGIT state, k = DIGITS-1 down to 0 with P[k] = 10^k:
    - If rem >= P[k]: rem -= P[k], cnt++, we=0.
    - Else: we=1, dat='0'+cnt (0x30|cnt), cnt cleared, k decrements.
    - A digit of value d therefore costs d+1 cycles.
    - Blanking: while blank_zeros=1 and every emitted digit so far is 0, a zero digit is written as ' '. Digit k=0 is always numeric, so value 0 shows '0'.
    - Overflow: every digit cycle writes '#' (0x23) with no subtraction, one cycle each.
  - col3+DIGITS..LINE_LEN-1: ' ' (0x20).
- After the last column of channel NUM_CH-1: next cycle we=0, busy=0, done=1 for one cycle, FSM returns to IDLE. start in the done cycle is accepted.
- Total cycles, start to done: 1 + NUM_CH*LINE_LEN + sum of all digit values (overflowed channels contribute 0).
- we is 0 outside busy. addr never exceeds NUM_CH*LINE_LEN-1.

Test Plan:
- Defaults, unsigned, labels 'X','Y', numbers {0, 4294967295}, blank_zeros=0 -> addr0..15 = "X: 0000000000   ", addr16..31 = "Y: 4294967295   ". done exactly 1+32+57 = 90 cycles after start.
- signed_mode=1, numbers {0xFFFFFFFF, 0x80000000}, blank_zeros=1 -> "X:-         1   " and "Y:-2147483648   ".
- DIGITS=4, LINE_LEN=8, NUM_CH=1, value 12345 -> "X: #### ". Value 9999 -> "X: 9999 ". Value 0 with blank_zeros=1 -> "X:    0 ".
- start pulsed again mid-run, and numbers changed mid-run -> ignored; output matches the first snapshot; exactly one done pulse.
- rst asserted at the 10th busy cycle -> next cycle we=0, busy=0, done=0. A fresh start then produces a complete correct field.
- Labels 'R',0xF2, value 1000000000, blank_zeros=1 -> "R: 1000000000   "; second field starts with byte 0xF2 at addr16.
